pipe_ctrl: RTL and testbench

Central hazard and flush controller for the five-stage pipeline. It produces the hold (stall) and synchronous-clear strobes for the F/D/E/M/W pipeline registers, so each register stage only has to obey `clr` and `en`. It also owns the multiply/divide busy counter. It sequences exception/interrupt entry and `eret` return by driving the CP0 PC redirect.

---
 rtl/pipe_ctrl.sv | 96 +++++++++
 tb/tb_pipe_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Hazard/flush controller: stall and clear strobes for the F/D/E/M/W
// registers, the mult/div busy counter, and exception/eret PC redirect.
module pipe_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic stall_req_D,
   input  logic md_start_E,
   input  logic md_is_div_E,
   input  logic md_use_D,
   input  logic exc_M,
   input  logic eret_D,
   input  logic mtc0_epc_E,
   input  logic mtc0_epc_M,
   output logic stallF,
   output logic stallD,
   output logic clrD,
   output logic clrE,
   output logic clrM,
   output logic clrW,
   output logic pc_sel_exc,
   output logic pc_sel_epc,
   output logic md_busy
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
   localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

   state_t     st;
   state_t     stNext;
   logic [3:0] mdCnt;
   logic       excTake;
   logic       eretRun;
   logic       epcPend;
   logic       stall;

   assign md_busy = (mdCnt != 4'd0);
   assign excTake = exc_M && (st == RUN);
   assign eretRun = eret_D && (st == RUN);
   assign epcPend = mtc0_epc_E || mtc0_epc_M;
   assign stall   = stall_req_D || (md_use_D && (md_busy || md_start_E));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st <= RUN;
      end else begin
         st <= stNext;
      end
   end

   // A start killed by a coincident exception is younger; it never loads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mdCnt <= 4'd0;
      end else if (md_start_E && !excTake) begin
         mdCnt <= md_is_div_E ? DivLoad : MultLoad;
      end else if (mdCnt != 4'd0) begin
         mdCnt <= mdCnt - 4'd1;
      end
   end

   always_comb begin
      stNext     = RUN;
      stallF     = 1'b0;
      stallD     = 1'b0;
      clrD       = 1'b0;
      clrE       = 1'b0;
      clrM       = 1'b0;
      clrW       = 1'b0;
      pc_sel_exc = 1'b0;
      pc_sel_epc = 1'b0;
      if (!reset) begin
         if (excTake) begin
            clrD       = 1'b1;
            clrE       = 1'b1;
            clrM       = 1'b1;
            clrW       = 1'b1;
            pc_sel_exc = 1'b1;
            stNext     = FLUSH;
         end else if (eretRun && !epcPend) begin
            pc_sel_epc = 1'b1;
            clrD       = 1'b1;
         end else if (stall || eretRun) begin
            // eret waits here until the EPC write ahead of it retires
            stallF = 1'b1;
            stallD = 1'b1;
            clrE   = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Outputs packed as {stallF,stallD,clrD,clrE,clrM,clrW,exc,epc,busy}.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic stall_req_D, md_start_E, md_is_div_E, md_use_D;
   logic exc_M, eret_D, mtc0_epc_E, mtc0_epc_M;
   logic stallF, stallD, clrD, clrE, clrM, clrW;
   logic pc_sel_exc, pc_sel_epc, md_busy;

   int nChecks = 0;
   int nErrors = 0;

   localparam logic [8:0] NONE = 9'b000000000;
   localparam logic [8:0] STL  = 9'b110100000;
   localparam logic [8:0] EXC  = 9'b001111100;
   localparam logic [8:0] ERT  = 9'b001000010;
   localparam logic [8:0] BSY  = 9'b000000001;

   pipe_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .stall_req_D(stall_req_D), .md_start_E(md_start_E),
      .md_is_div_E(md_is_div_E), .md_use_D(md_use_D),
      .exc_M(exc_M), .eret_D(eret_D),
      .mtc0_epc_E(mtc0_epc_E), .mtc0_epc_M(mtc0_epc_M),
      .stallF(stallF), .stallD(stallD),
      .clrD(clrD), .clrE(clrE), .clrM(clrM), .clrW(clrW),
      .pc_sel_exc(pc_sel_exc), .pc_sel_epc(pc_sel_epc),
      .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   wire [8:0] outv = {stallF, stallD, clrD, clrE, clrM, clrW,
                      pc_sel_exc, pc_sel_epc, md_busy};

   task automatic check(input string tag, input logic [8:0] got,
                        input logic [8:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Inputs settle 1ns after the edge; sample mid-cycle, then advance.
   task automatic tick(input string tag, input logic [8:0] exp);
      #3;
      check(tag, outv, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall_req_D = 0; md_start_E = 0; md_is_div_E = 0; md_use_D = 0;
      exc_M = 0; eret_D = 0; mtc0_epc_E = 0; mtc0_epc_M = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      stall_req_D = 1;
      for (int i = 0; i < 3; i++) tick($sformatf("rst%0d", i), NONE);
      stall_req_D = 0;
      reset = 0;
      tick("post_rst0", NONE);
      tick("post_rst1", NONE);

      stall_req_D = 1;
      tick("raw_stall", STL);
      stall_req_D = 0;

      // div start with a dependent HI/LO reader in D
      md_start_E = 1; md_is_div_E = 1; md_use_D = 1;
      tick("div_start", STL);
      md_start_E = 0; md_is_div_E = 0;
      for (int i = 1; i <= 10; i++)
         tick($sformatf("div_busy%0d", i), STL | BSY);
      tick("div_done", NONE);
      md_use_D = 0;

      // mult without reader: busy for exactly 5 cycles
      md_start_E = 1;
      tick("mul_start", NONE);
      md_start_E = 0;
      for (int i = 1; i <= 5; i++)
         tick($sformatf("mul_busy%0d", i), BSY);
      tick("mul_done", NONE);

      // exception kills a coincident start; second exc_M dropped
      exc_M = 1; md_start_E = 1;
      tick("exc_kill", EXC);
      md_start_E = 0;
      tick("exc_flush", NONE);
      tick("exc_again", EXC);
      exc_M = 0;
      tick("exc_flush2", NONE);
      tick("exc_idle", NONE);

      // exception while an older mult runs: counter keeps going
      md_start_E = 1;
      tick("mul2_start", NONE);
      md_start_E = 0; exc_M = 1;
      tick("exc_busy", EXC | BSY);
      exc_M = 0; stall_req_D = 1;
      tick("flush_stall", STL | BSY);
      stall_req_D = 0;
      tick("mul2_b3", BSY);
      tick("mul2_b4", BSY);
      tick("mul2_b5", BSY);
      tick("mul2_done", NONE);

      // eret behind a pending EPC write
      eret_D = 1; mtc0_epc_M = 1;
      tick("eret_wait_M", STL);
      mtc0_epc_M = 0;
      tick("eret_go", ERT);
      mtc0_epc_E = 1;
      tick("eret_wait_E", STL);
      mtc0_epc_E = 0;
      exc_M = 1;
      tick("exc_eret", EXC);
      exc_M = 0; eret_D = 0;
      tick("exc_eret_fl", NONE);

      // reset in the cycle after a mult start
      md_start_E = 1;
      tick("mul3_start", NONE);
      md_start_E = 0;
      #1 check("mul3_busy", outv, BSY);
      reset = 1;
      #1 check("rst_async", outv, NONE);
      @(posedge clk);
      #1;
      reset = 0; md_use_D = 1;
      tick("rst_nostall0", NONE);
      tick("rst_nostall1", NONE);
      idle();

      $display("Simulation finished: %0d checks, %0d errors",
               nChecks, nErrors);
      $finish;
   end

endmodule
